dlfp16_sgnj_issue: RTL

//   Issue/collect front end for the combinational DLFloat16 sign-injection unit.
//   - Accepts sign-op requests (opcode, two operands, tag) on a valid/ready channel.
//   - Decodes the opcode into the unit's 2-bit select and drives the unit from a register stage.
//   - Captures the unit's result, buffers it in an in-order response FIFO and returns it on a valid/ready channel.
//   - Sits between the FPU instruction decoder and the sign-injection datapath.

---
 rtl/dlfp16_pkg.sv | 22 ++
 rtl/dlfp16_rsp_fifo.sv | 51 +++++
 rtl/dlfp16_sgnj_issue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dlfp16_pkg.sv
// rtl/dlfp16_pkg.sv - shared DLFloat16 sign-injection constants
//
// Purpose: opcode and sign-unit select encodings shared by the issue front end
//          and anything else that talks to the sign-injection datapath.
// Ports:   none (package).
package dlfp16_pkg;

   localparam int DLF16_W = 16;

   // request opcodes; any opcode with bit 2 set is illegal
   localparam logic [2:0] OP_FSGNJ  = 3'b000;
   localparam logic [2:0] OP_FSGNJN = 3'b001;
   localparam logic [2:0] OP_FSGNJX = 3'b010;
   localparam logic [2:0] OP_FNEG   = 3'b011;

   // sign-unit select encodings
   localparam logic [1:0] SEL_INV  = 2'b00;
   localparam logic [1:0] SEL_INJ  = 2'b01;
   localparam logic [1:0] SEL_INJN = 2'b10;
   localparam logic [1:0] SEL_INJX = 2'b11;

endpackage

// File: rtl/dlfp16_rsp_fifo.sv
// rtl/dlfp16_rsp_fifo.sv - in-order show-ahead response FIFO
//
// Purpose: buffers captured sign-unit results; the head entry is visible
//          combinationally from storage with no extra cycle.
// Ports:   clk, rst_n      clock, asynchronous active-low reset
//          push, push_data write one entry (caller guarantees not full)
//          pop             retire the head (caller guarantees not empty)
//          head_data       current head entry
//          count           number of stored entries
module dlfp16_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 21
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth: wraps naturally
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dlfp16_sgnj_issue.sv
// rtl/dlfp16_sgnj_issue.sv - issue/collect front end for the DLFloat16 sign unit
//
// Purpose: accepts sign-op requests, drives the external combinational sign
//          unit from a one-entry register stage, captures its result into an
//          in-order response FIFO and returns it on a valid/ready channel.
// Ports:   clk, rst_n                      clock, asynchronous active-low reset
//          req_valid/req_ready/req_op/req_a/req_b/req_tag   request channel
//          sgn_in1/sgn_in2/sgn_sel/sgn_out                  sign-unit interface
//          rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_illegal response channel
//          busy                            work in stage 1 or FIFO
module dlfp16_sgnj_issue
   import dlfp16_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_op,
   input  logic [15:0]        req_a,
   input  logic [15:0]        req_b,
   input  logic [TAG_W-1:0]   req_tag,
   output logic [15:0]        sgn_in1,
   output logic [15:0]        sgn_in2,
   output logic [1:0]         sgn_sel,
   input  logic [15:0]        sgn_out,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [15:0]        rsp_data,
   output logic [TAG_W-1:0]   rsp_tag,
   output logic               rsp_illegal,
   output logic               busy
);

   localparam int CW = $clog2(DEPTH) + 1;   // FIFO count width
   localparam int FW = DLF16_W + TAG_W + 1; // FIFO entry width

   logic               s1_valid;
   logic [2:0]         s1_op;
   logic [15:0]        s1_a;
   logic [15:0]        s1_b;
   logic [TAG_W-1:0]   s1_tag;
   logic               s1_illegal;

   logic [CW-1:0]      fifo_count;
   logic [FW-1:0]      fifo_head;
   logic [FW-1:0]      fifo_wdata;
   logic [CW:0]        in_flight;
   logic               accept;
   logic               pop;

   // Credit: stage 1 always pushes next edge, so reserve a slot for it.
   assign in_flight = {1'b0, fifo_count} + (CW+1)'(s1_valid);
   assign req_ready = rst_n && (in_flight < (CW+1)'(DEPTH));
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tag   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_op  <= req_op;
            s1_a   <= req_a;
            s1_b   <= req_b;
            s1_tag <= req_tag;
         end
      end
   end

   assign s1_illegal = s1_op[2];

   always_comb begin
      sgn_sel = SEL_INV;
      sgn_in1 = '0;
      sgn_in2 = '0;
      if (s1_valid && !s1_illegal) begin
         sgn_in1 = s1_b;
         sgn_in2 = s1_a;
         case (s1_op)
            OP_FSGNJ:  sgn_sel = SEL_INJ;
            OP_FSGNJN: sgn_sel = SEL_INJN;
            OP_FSGNJX: sgn_sel = SEL_INJX;
            default: begin
               // FNEG: invert the sign of a, fed on both inputs
               sgn_sel = SEL_INV;
               sgn_in1 = s1_a;
               sgn_in2 = s1_a;
            end
         endcase
      end
   end

   // Illegal ops return zero data regardless of what the unit produces.
   assign fifo_wdata = {(s1_illegal ? 16'h0000 : sgn_out), s1_tag, s1_illegal};
   assign pop        = rsp_valid && rsp_ready;

   dlfp16_rsp_fifo #(
      .DEPTH (DEPTH),
      .W     (FW)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (s1_valid),
      .push_data (fifo_wdata),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign rsp_valid   = (fifo_count != '0);
   assign rsp_data    = fifo_head[FW-1 -: 16];
   assign rsp_tag     = fifo_head[TAG_W:1];
   assign rsp_illegal = fifo_head[0];
   assign busy        = s1_valid || rsp_valid;

endmodule
